// File: rtl/reorder_buffer.sv
// -----------------------------------------------------------------------------
// reorder_buffer
//   In-order retirement queue between the decoder/issue stage and the register
//   file. Each issued instruction gets one slot, and the slot index is returned
//   as its rename tag. Results arrive out of order on the CDB writeback bus.
//   Ready head entries retire in program order, at most one per cycle. When a
//   mispredicted branch retires, a one-cycle flush is raised and the whole
//   buffer empties. Two combinational operand-query ports let the decoder read
//   completed results by tag.
//
// Handshake:
//   issue is a request and full is its inverted ready. A slot is granted only
//   on a posedge where issue=1, full=0 and rdy=1; issue_pos names that slot.
//   Writeback has no back-pressure. A wb_valid to a slot that is not busy is
//   ignored. commit and flush are registered one-cycle pulses and need no
//   acknowledgement.
//
// Ports:
//   clk, rst_n (sync, active low), rdy (global enable; state frozen when low)
//   issue, issue_rd                   -> issue_pos, full
//   wb_valid, wb_pos, wb_val, wb_mispred, wb_pc
//   q1_pos/q2_pos                     -> q1_ready/q2_ready, q1_val/q2_val
//   commit, commit_rd, commit_val, commit_rob_pos
//   flush, flush_pc
//
// Configuration macro:
//   ROB_BYPASS_EN  When defined, a query also sees a same-cycle CDB result
//                  aimed at a busy slot. When undefined, queries see only
//                  stored state.
// -----------------------------------------------------------------------------
module reorder_buffer #(
  parameter int ROB_SIZE  = 16,
  parameter int ROB_POS_W = 4,
  parameter int DATA_W    = 32,
  parameter int REG_POS_W = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rdy,
  input  logic                 issue,
  input  logic [REG_POS_W-1:0] issue_rd,
  output logic [ROB_POS_W-1:0] issue_pos,
  output logic                 full,
  input  logic                 wb_valid,
  input  logic [ROB_POS_W-1:0] wb_pos,
  input  logic [DATA_W-1:0]    wb_val,
  input  logic                 wb_mispred,
  input  logic [DATA_W-1:0]    wb_pc,
  input  logic [ROB_POS_W-1:0] q1_pos,
  input  logic [ROB_POS_W-1:0] q2_pos,
  output logic                 q1_ready,
  output logic                 q2_ready,
  output logic [DATA_W-1:0]    q1_val,
  output logic [DATA_W-1:0]    q2_val,
  output logic                 commit,
  output logic [REG_POS_W-1:0] commit_rd,
  output logic [DATA_W-1:0]    commit_val,
  output logic [ROB_POS_W-1:0] commit_rob_pos,
  output logic                 flush,
  output logic [DATA_W-1:0]    flush_pc
);

  localparam logic [ROB_POS_W:0] CAP = (ROB_POS_W+1)'(ROB_SIZE);
  localparam logic [ROB_POS_W:0] ONE = (ROB_POS_W+1)'(1);

  // Per-slot status bits. They are kept as vectors so that reset and flush
  // can clear them in one assignment.
  logic [ROB_SIZE-1:0]  busy;
  logic [ROB_SIZE-1:0]  ready;
  logic [ROB_SIZE-1:0]  mispred;

  // Per-slot payload. It is never read unless the matching busy/ready bits
  // say so, so it needs no reset.
  logic [REG_POS_W-1:0] rd_mem  [ROB_SIZE];
  logic [DATA_W-1:0]    val_mem [ROB_SIZE];
  logic [DATA_W-1:0]    pc_mem  [ROB_SIZE];

  logic [ROB_POS_W-1:0] head;
  logic [ROB_POS_W-1:0] tail;
  logic [ROB_POS_W:0]   count;

  logic do_issue;
  logic do_wb;
  logic do_commit;
  logic do_flush;

  assign full      = (count == CAP);
  assign issue_pos = tail;

  // Issue is dropped while full, even if a commit frees a slot on the same
  // edge. This keeps the tail from landing on the slot that is retiring.
  assign do_issue  = issue && !full;
  assign do_wb     = wb_valid && busy[wb_pos];
  // busy is checked as well as ready. A slot that retires on the same edge
  // as a late writeback can keep a stale ready bit after busy is cleared.
  assign do_commit = (count != '0) && busy[head] && ready[head];
  assign do_flush  = do_commit && mispred[head];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy           <= '0;
      ready          <= '0;
      mispred        <= '0;
      head           <= '0;
      tail           <= '0;
      count          <= '0;
      commit         <= 1'b0;
      commit_rd      <= '0;
      commit_val     <= '0;
      commit_rob_pos <= '0;
      flush          <= 1'b0;
      flush_pc       <= '0;
    end else if (rdy) begin
      commit <= do_commit;
      flush  <= do_flush;
      if (do_commit) begin
        commit_rd      <= rd_mem[head];
        commit_val     <= val_mem[head];
        commit_rob_pos <= head;
      end
      if (do_flush) begin
        // A mispredicted branch retires and empties the buffer. Any issue or
        // writeback on this same edge is lost with the rest.
        flush_pc <= pc_mem[head];
        busy     <= '0;
        ready    <= '0;
        mispred  <= '0;
        head     <= '0;
        tail     <= '0;
        count    <= '0;
      end else begin
        if (do_wb) begin
          ready[wb_pos]   <= 1'b1;
          mispred[wb_pos] <= wb_mispred;
        end
        if (do_commit) begin
          busy[head] <= 1'b0;
          head       <= head + 1'b1;
        end
        // Issue is assigned last. This way a fresh slot always starts clean.
        if (do_issue) begin
          busy[tail]    <= 1'b1;
          ready[tail]   <= 1'b0;
          mispred[tail] <= 1'b0;
          tail          <= tail + 1'b1;
        end
        case ({do_issue, do_commit})
          2'b10:   count <= count + ONE;
          2'b01:   count <= count - ONE;
          default: count <= count;
        endcase
      end
    end else begin
      commit <= 1'b0;
      flush  <= 1'b0;
    end
  end

  // Payload writes. Writes made on a flush edge are harmless, because the
  // status bits are cleared on that same edge.
  always_ff @(posedge clk) begin
    if (rdy) begin
      if (do_issue) begin
        rd_mem[tail] <= issue_rd;
      end
      if (do_wb) begin
        val_mem[wb_pos] <= wb_val;
        pc_mem[wb_pos]  <= wb_pc;
      end
    end
  end

  // Operand queries
  always_comb begin
    q1_ready = busy[q1_pos] && ready[q1_pos];
    q1_val   = q1_ready ? val_mem[q1_pos] : '0;
    q2_ready = busy[q2_pos] && ready[q2_pos];
    q2_val   = q2_ready ? val_mem[q2_pos] : '0;
`ifdef ROB_BYPASS_EN
    // Forward a result that is on the CDB this cycle to a dependent that is
    // issuing now.
    if (wb_valid && (wb_pos == q1_pos) && busy[q1_pos]) begin
      q1_ready = 1'b1;
      q1_val   = wb_val;
    end
    if (wb_valid && (wb_pos == q2_pos) && busy[q2_pos]) begin
      q2_ready = 1'b1;
      q2_val   = wb_val;
    end
`endif
  end

endmodule
